// File: rtl/wb_post_exerciser_pkg.sv
// Shared definitions for the POST/GPIO bus exerciser and the wb_switch I/O
// decode: sequencer state encoding, I/O base addresses and TGA encodings.
package wb_post_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_POST = 2'd1,
    ST_RD_GPIO = 2'd2,
    ST_ERR     = 2'd3
  } seq_state_t;

  // Byte addresses in I/O space
  localparam logic [15:0] IO_POST_BASE = 16'h0080;
  localparam logic [15:0] IO_GPIO_BASE = 16'hF100;

  // Address-space tag carried on wb_tga
  localparam logic TGA_IO  = 1'b1;
  localparam logic TGA_MEM = 1'b0;

  // Byte-lane selects
  localparam logic [1:0] SEL_LO_BYTE = 2'b01;
  localparam logic [1:0] SEL_WORD    = 2'b11;

  // Byte I/O address to the 19-bit word address driven on wb_adr [19:1]
  function automatic logic [18:0] io_word_adr(input logic [15:0] byte_adr);
    return {4'b0000, byte_adr[15:1]};
  endfunction

endpackage

// File: rtl/wb_master_xfer.sv
// Single-transfer Wishbone initiator with an ack watchdog. A start pulse while
// idle latches the bus fields and raises cyc/stb on the next edge; the
// transfer ends on ack (done) or when the watchdog expires (timeout).
module wb_master_xfer
  import wb_post_exerciser_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic        tga,
  input  logic [18:0] adr,
  input  logic [15:0] dat,
  input  logic [1:0]  sel,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic [18:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic            stb_reg;
  logic            we_reg;
  logic            tga_reg;
  logic [18:0]     adr_reg;
  logic [15:0]     dat_reg;
  logic [1:0]      sel_reg;
  logic [WD_W-1:0] wd_cnt_reg;

  logic ack_hit;
  logic wd_expire;

  // Ack only counts inside a strobe; an ack on the last watchdog cycle wins.
  assign ack_hit   = stb_reg & wb_ack_i;
  assign wd_expire = stb_reg & ~wb_ack_i & (wd_cnt_reg == WD_LAST);

  // Bus field registers and watchdog; fields are frozen for the whole strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_reg    <= 1'b0;
      we_reg     <= 1'b0;
      tga_reg    <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      sel_reg    <= '0;
      wd_cnt_reg <= '0;
    end else if (stb_reg) begin
      if (ack_hit || wd_expire) begin
        // Return the bus to an all-zero idle state
        stb_reg    <= 1'b0;
        we_reg     <= 1'b0;
        tga_reg    <= 1'b0;
        adr_reg    <= '0;
        dat_reg    <= '0;
        sel_reg    <= '0;
        wd_cnt_reg <= '0;
      end else begin
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      end
    end else if (start) begin
      stb_reg    <= 1'b1;
      we_reg     <= we;
      tga_reg    <= tga;
      adr_reg    <= adr;
      dat_reg    <= dat;
      sel_reg    <= sel;
      wd_cnt_reg <= '0;
    end
  end

  assign wb_cyc_o = stb_reg;
  assign wb_stb_o = stb_reg;
  assign wb_we_o  = we_reg;
  assign wb_tga_o = tga_reg;
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign wb_sel_o = sel_reg;
  assign busy     = stb_reg;
  assign done     = ack_hit;
  assign timeout  = wd_expire;

endmodule

// File: rtl/wb_post_exerciser.sv
// Bring-up bus master: every PERIOD cycles writes an incrementing POST code to
// the POST port, then reads the GPIO switch register. A slave that never
// acknowledges parks the sequencer in ERR until clr_err_i.
module wb_post_exerciser
  import wb_post_exerciser_pkg::*;
#(
  parameter logic [15:0] POST_ADDR = IO_POST_BASE,
  parameter logic [15:0] GPIO_ADDR = IO_GPIO_BASE,
  parameter int          PERIOD    = 12500,
  parameter int          TIMEOUT   = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic        clr_err_i,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [15:0] wb_dat_o,
  output logic [18:0] wb_adr_o,
  output logic        wb_tga_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [7:0]  postcode_o,
  output logic [15:0] gpio_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int                PER_W     = $clog2(PERIOD);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
  localparam logic [18:0]       POST_WADR = io_word_adr(POST_ADDR);
  localparam logic [18:0]       GPIO_WADR = io_word_adr(GPIO_ADDR);

  seq_state_t       state_reg, state_next;
  logic [PER_W-1:0] period_reg, period_next;
  logic [7:0]       postcode_reg, postcode_next;
  logic [15:0]      gpio_reg, gpio_next;
  logic             err_reg, err_next;

  logic        xfer_start;
  logic        xfer_we;
  logic [18:0] xfer_adr;
  logic [15:0] xfer_dat;
  logic [1:0]  xfer_sel;
  logic        xfer_busy;
  logic        xfer_done;
  logic        xfer_timeout;

  logic [7:0]  code_inc;
  logic [15:0] post_dat;

  // Next POST code wraps naturally at 8 bits and is replicated on both lanes
  assign code_inc = postcode_reg + 8'd1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_post_lane
    assign post_dat[gi*8 +: 8] = code_inc;
  end

  // Sequencer and status registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg    <= ST_IDLE;
      period_reg   <= '0;
      postcode_reg <= '0;
      gpio_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      postcode_reg <= postcode_next;
      gpio_reg     <= gpio_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic; a transfer is launched on the cycle after each state
  // entry because the engine only accepts start while its strobe is low.
  always_comb begin
    state_next    = state_reg;
    period_next   = period_reg;
    postcode_next = postcode_reg;
    gpio_next     = gpio_reg;
    err_next      = err_reg;
    xfer_start    = 1'b0;
    xfer_we       = 1'b0;
    xfer_adr      = '0;
    xfer_dat      = '0;
    xfer_sel      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (enable_i) begin
          if (period_reg == PER_LAST) begin
            period_next = '0;
            state_next  = ST_WR_POST;
          end else begin
            period_next = period_reg + PER_W'(1);
          end
        end
      end
      ST_WR_POST: begin
        xfer_start = ~xfer_busy;
        xfer_we    = 1'b1;
        xfer_adr   = POST_WADR;
        xfer_dat   = post_dat;
        xfer_sel   = SEL_LO_BYTE;
        if (xfer_done) begin
          postcode_next = code_inc;
          // Dropping enable abandons the pending read
          state_next    = enable_i ? ST_RD_GPIO : ST_IDLE;
        end else if (xfer_timeout) begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end
      end
      ST_RD_GPIO: begin
        xfer_start = ~xfer_busy;
        xfer_we    = 1'b0;
        xfer_adr   = GPIO_WADR;
        xfer_sel   = SEL_WORD;
        if (xfer_done) begin
          gpio_next  = wb_dat_i;
          state_next = ST_IDLE;
        end else if (xfer_timeout) begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        if (clr_err_i) begin
          err_next    = 1'b0;
          period_next = '0;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  wb_master_xfer #(
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .start    (xfer_start),
    .we       (xfer_we),
    .tga      (TGA_IO),
    .adr      (xfer_adr),
    .dat      (xfer_dat),
    .sel      (xfer_sel),
    .wb_ack_i (wb_ack_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_tga_o (wb_tga_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .busy     (xfer_busy),
    .done     (xfer_done),
    .timeout  (xfer_timeout)
  );

  assign postcode_o = postcode_reg;
  assign gpio_o     = gpio_reg;
  assign err_o      = err_reg;
  assign busy_o     = xfer_busy;

endmodule

// File: tb/tb_wb_post_exerciser.sv
// Bench for wb_post_exerciser: a parameterisable slave model, a scoreboard of
// expected bus transactions checked at each ack, a table of sequence runs
// and hand-written sequences for timeout, enable drop and reset corners.
module tb_wb_post_exerciser;

  localparam int PERIOD  = 8;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic [15:0] wb_dat_o;
  logic [18:0] wb_adr_o;
  logic        wb_tga_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [7:0]  postcode_o;
  logic [15:0] gpio_o;
  logic        busy_o;
  logic        err_o;

  wb_post_exerciser #(
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .enable_i   (enable),
    .clr_err_i  (clr_err),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_dat_o   (wb_dat_o),
    .wb_adr_o   (wb_adr_o),
    .wb_tga_o   (wb_tga_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .postcode_o (postcode_o),
    .gpio_o     (gpio_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          ack_delay = 1;   // stb cycles before ack; 0 = same cycle
  logic        post_noack = 1'b0;
  logic [15:0] gpio_val = 16'h0000;
  int          wait_cnt = 0;

  always @(posedge clk) wait_cnt <= (wb_stb_o && !wb_ack_i) ? wait_cnt + 1 : 0;

  assign wb_ack_i = wb_stb_o && (wait_cnt == ack_delay) && !(post_noack && wb_we_o);
  assign wb_dat_i = (wb_stb_o && !wb_we_o) ? gpio_val : 16'h0000;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [18:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    int          len;
    int          gap;   // idle cycles before strobe, -1 = not checked
  } xfer_t;

  xfer_t       exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          stb_starts = 0;
  int          noack_cnt = 0;
  int          noack_len = 0;
  logic [15:0] last_wr_dat = 16'h0000;
  logic [7:0]  exp_pc = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transaction monitor: samples on the falling edge, compares at each ack
  initial begin : monitor
    logic        in_xfer, stable, cs_ok, ok;
    int          len, gap, cur_gap;
    logic        cap_we, cap_tga;
    logic [18:0] cap_adr;
    logic [1:0]  cap_sel;
    logic [15:0] cap_dat;
    xfer_t       e;
    in_xfer = 1'b0; stable = 1'b1; cs_ok = 1'b1; ok = 1'b0;
    len = 0; gap = 0; cur_gap = 0;
    cap_we = 1'b0; cap_tga = 1'b0; cap_adr = '0; cap_sel = '0; cap_dat = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o !== wb_stb_o) cs_ok = 1'b0;
      if (wb_stb_o === 1'b1) begin
        if (!in_xfer) begin
          in_xfer = 1'b1; len = 0; stable = 1'b1; cur_gap = gap;
          cap_we = wb_we_o; cap_tga = wb_tga_o; cap_adr = wb_adr_o;
          cap_sel = wb_sel_o; cap_dat = wb_dat_o;
          stb_starts++;
        end
        len++;
        if ({wb_we_o, wb_tga_o, wb_adr_o, wb_sel_o, wb_dat_o} !==
            {cap_we, cap_tga, cap_adr, cap_sel, cap_dat}) stable = 1'b0;
        if (wb_ack_i === 1'b1) begin
          in_xfer = 1'b0; gap = 0;
          if (cap_we) begin wr_cnt++; last_wr_dat = cap_dat; end
          else rd_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL xfer unexpected: got we=%b adr=%05h sel=%b dat=%04h, expected no transfer",
                     cap_we, cap_adr, cap_sel, cap_dat);
          end else begin
            e = exp_q.pop_front();
            ok = (cap_we == e.we) && (cap_adr == e.adr) && (cap_sel == e.sel) &&
                 (cap_tga == 1'b1) && (!e.we || cap_dat == e.dat) && (len == e.len) &&
                 (e.gap < 0 || cur_gap == e.gap) && stable && cs_ok;
            if (ok)
              $display("xfer %0d: %s adr=%05h sel=%b dat=%04h len=%0d ok",
                       wr_cnt + rd_cnt, cap_we ? "WR" : "RD", cap_adr, cap_sel,
                       cap_we ? cap_dat : wb_dat_i, len);
            else begin
              n_fail++;
              $display("FAIL xfer %0d: got we=%b tga=%b adr=%05h sel=%b dat=%04h len=%0d gap=%0d stable=%b cyc_eq_stb=%b, expected we=%b tga=1 adr=%05h sel=%b dat=%04h len=%0d gap=%0d",
                       wr_cnt + rd_cnt, cap_we, cap_tga, cap_adr, cap_sel, cap_dat, len, cur_gap,
                       stable, cs_ok, e.we, e.adr, e.sel, e.dat, e.len, e.gap);
            end
          end
          cs_ok = 1'b1;
        end
      end else begin
        if (in_xfer) begin
          in_xfer = 1'b0; noack_cnt++; noack_len = len;
        end
        gap++;
      end
    end
  end

  task automatic push_write();
    xfer_t w;
    exp_pc  = exp_pc + 8'd1;
    w.we  = 1'b1; w.adr = 19'h00040; w.sel = 2'b01; w.dat = {exp_pc, exp_pc};
    w.len = ack_delay + 1; w.gap = -1;
    exp_q.push_back(w);
  endtask

  task automatic push_read();
    xfer_t r;
    r.we  = 1'b0; r.adr = 19'h07880; r.sel = 2'b11; r.dat = gpio_val;
    r.len = ack_delay + 1; r.gap = 1;
    exp_q.push_back(r);
  endtask

  task automatic wait_reads(input int target, input int budget);
    int t;
    t = 0;
    while (rd_cnt < target && t < budget) begin tick(); t++; end
    check("reads_done", rd_cnt, target);
  endtask

  task automatic run_seqs(input int n);
    int target;
    for (int i = 0; i < n; i++) begin push_write(); push_read(); end
    target = rd_cnt + n;
    enable = 1'b1;
    wait_reads(target, n * 60 + 100);
    enable = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl/adr"}, {7'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o}, 32'h0);
    check({tag, " dat/gpio"}, {wb_dat_o, gpio_o}, 32'h0);
    check({tag, " pc/busy/err"}, {22'd0, postcode_o, busy_o, err_o}, 32'h0);
  endtask

  typedef struct {
    int          ack_dly;
    logic [15:0] gpio;
    int          nseq;
    logic [7:0]  pc;
  } vec_t;

  initial begin : global_guard
    #600000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[4];
    int   base_a, base_b, base_c, t;
    vecs[0] = '{1, 16'hA5C3, 1, 8'h01};
    vecs[1] = '{0, 16'h5A3C, 2, 8'h03};
    vecs[2] = '{2, 16'h0F0F, 1, 8'h04};
    vecs[3] = '{3, 16'h1234, 1, 8'h05};   // ack on the last watchdog cycle

    // Reset state
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_while_disabled", {stb_starts[30:0], busy_o}, 32'h0);

    // Table-driven sequence runs
    for (int i = 0; i < 4; i++) begin
      ack_delay = vecs[i].ack_dly;
      gpio_val  = vecs[i].gpio;
      run_seqs(vecs[i].nseq);
      check($sformatf("vec%0d postcode", i), postcode_o, vecs[i].pc);
      check($sformatf("vec%0d gpio", i), gpio_o, vecs[i].gpio);
      check($sformatf("vec%0d err/busy", i), {err_o, busy_o}, 0);
      check($sformatf("vec%0d queue", i), exp_q.size(), 0);
    end

    // POST slave never acks: watchdog, ERR stays quiet, clr_err recovers
    ack_delay = 1; post_noack = 1'b1;
    base_a = noack_cnt; base_b = stb_starts;
    enable = 1'b1;
    t = 0;
    while (err_o !== 1'b1 && t < 200) begin tick(); t++; end
    check("timeout err_o", err_o, 1);
    repeat (30) tick();
    check("timeout stb_len", noack_len, TIMEOUT);
    check("timeout count", noack_cnt, base_a + 1);
    check("timeout no_more_cycles", stb_starts, base_b + 1);
    check("timeout postcode", postcode_o, 8'h05);
    check("timeout err held", {err_o, busy_o}, 2'b10);
    post_noack = 1'b0;
    push_write(); push_read();
    base_a = rd_cnt + 1;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_err err_o", err_o, 0);
    wait_reads(base_a, 200);
    enable = 1'b0;
    check("after_clr postcode", postcode_o, 8'h06);

    // enable drops while the write is in flight: no read follows
    ack_delay = 3;
    push_write();
    base_a = rd_cnt; base_b = stb_starts; base_c = wr_cnt;
    enable = 1'b1;
    t = 0;
    while (wb_stb_o !== 1'b1 && t < 100) begin tick(); t++; end
    check("edrop stb_seen", wb_stb_o, 1);
    enable = 1'b0;
    t = 0;
    while (wr_cnt < base_c + 1 && t < 50) begin tick(); t++; end
    repeat (30) tick();
    check("edrop write_done", wr_cnt, base_c + 1);
    check("edrop no_read", rd_cnt, base_a);
    check("edrop one_strobe", stb_starts, base_b + 1);
    check("edrop postcode", postcode_o, 8'h07);
    check("edrop idle", {busy_o, exp_q.size() != 0}, 0);
    ack_delay = 1;
    run_seqs(1);
    check("reenable postcode", postcode_o, 8'h08);

    // Reset in the middle of a read
    ack_delay = 3;
    push_write();
    enable = 1'b1;
    t = 0;
    while (!(wb_stb_o === 1'b1 && wb_we_o === 1'b0) && t < 100) begin tick(); t++; end
    check("midread stb_seen", {wb_stb_o, wb_we_o}, 2'b10);
    rst_n = 1'b0;
    #1 check_all_zero("midread_reset");
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_pc = 8'h00;
    tick();
    ack_delay = 1;
    run_seqs(1);
    check("post_reset first_dat", last_wr_dat, 16'h0101);
    check("post_reset postcode", postcode_o, 8'h01);

    // Wrap: the 256th write after reset carries 0x0000
    base_c = wr_cnt;
    run_seqs(255);
    check("wrap writes", wr_cnt, base_c + 255);
    check("wrap last_dat", last_wr_dat, 16'h0000);
    check("wrap postcode", postcode_o, 8'h00);
    check("wrap queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_post_exerciser.md
Name: wb_post_exerciser

Overview:
- Wishbone bus master (initiator) for board bring-up: the initiating end of the slave ports on the I/O map.
- Periodically writes an incrementing POST code to the postcode port (io 0x0080), then reads the GPIO switch register (io 0xF100) and exposes the result.
- Replaces the CPU on a bring-up build as the master port of wb_switch, so the post, sw_leds and hex display paths can be checked without a running BIOS.
- Bus watchdog: detects slaves that never acknowledge.

Parameters:
- POST_ADDR, 16'h0080: byte I/O address of the POST port. Must be even.
- GPIO_ADDR, 16'hF100: byte I/O address of the GPIO register. Must be even.
- PERIOD, 12500: cycles between sequence starts (1 ms at 12.5 MHz). Must be ≥ 2.
- TIMEOUT, 64: cycles a strobe may wait for ack. Must be ≥ 1.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  run sequences while high
- clr_err_i  in  1  one-cycle pulse: leave ERR state, clear err_o
- wb_dat_i  in  16  read data from switch
- wb_ack_i  in  1  slave acknowledge
- wb_dat_o  out  16  write data
- wb_adr_o  out  19  word address [19:1]
- wb_tga_o  out  1  1 = I/O space
- wb_sel_o  out  2  byte selects
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- postcode_o  out  8  last code acknowledged by the POST port
- gpio_o  out  16  last GPIO read value
- busy_o  out  1  a bus cycle is in progress
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync release): every output 0; state IDLE; counters 0.
- States: IDLE, WR_POST, RD_GPIO, ERR. All outputs are registered.
- IDLE
  - Period counter increments while enable_i=1; it holds while enable_i=0.
  - When the counter reaches PERIOD-1: counter returns to 0, state goes to WR_POST, and cyc/stb assert on the next edge.
- WR_POST bus fields:
  - tga=1, we=1, adr=POST_ADDR[15:1] zero-extended to 19 bits (0x00040 at default), sel=2'b01.
  - dat_o = {postcode_o+1, postcode_o+1}, computed mod 256.
- WR_POST on ack:
  - postcode_o increments; FF wraps to 00.
  - cyc/stb/we drop on the same edge, and state goes to RD_GPIO.
  - RD_GPIO strobe asserts on the following edge, giving one idle cycle between accesses.
- RD_GPIO bus fields: tga=1, we=0, adr=GPIO_ADDR[15:1] (0x07880 at default), sel=2'b11.
- RD_GPIO on ack: gpio_o <= wb_dat_i; cyc/stb drop; state goes to IDLE.
- Handshake:
  - cyc and stb are always equal.
  - Once asserted, adr/dat/sel/we/tga are held stable until the ack edge.
  - Ack is sampled only while stb=1; ack outside a cycle is ignored.
  - Zero-wait-state slaves must work (ack in the first stb cycle).
  - Single transfers only; no bursts.
- busy_o = cyc_o.
- Watchdog:
  - The counter clears when stb asserts and increments each cycle stb=1 without ack.
  - If the counter reaches TIMEOUT-1 with no ack: cyc/stb drop, err_o=1, state goes to ERR.
  - postcode_o and gpio_o are not updated on timeout.
  - If ack arrives on the same cycle the counter reaches TIMEOUT-1, ack wins.
- ERR:
  - No bus activity.
  - clr_err_i causes err_o=0, state IDLE, period counter 0.
  - clr_err_i in any other state is ignored.
- enable_i falling during WR_POST or RD_GPIO:
  - The current transfer completes, or times out.
  - The sequence then returns to IDLE and does not start the read if one is pending.
  - The period counter holds.
- Reset mid-cycle: cyc/stb drop immediately (asynchronous).

Decomposition:
- Shared package: state encoding, the I/O base constants (POST 0x0080, GPIO 0xF100) and the TGA_IO/TGA_MEM constants; the same constants are used for the wb_switch decode.
- One natural sub-module, wb_master_xfer: single-transfer engine with start/we/adr/dat/sel inputs, done/timeout outputs and the watchdog. wb_post_exerciser contains the sequencer FSM and the period counter.

Test Plan:
- Default params, PERIOD=8 for sim, enable=1, slave acks 1 cycle after stb:
  - first write adr=0x00040, tga=1, sel=01, dat=0x0101;
  - postcode_o=0x01 after ack;
  - read adr=0x07880 returns 0xA5C3, so gpio_o=0xA5C3.
- Zero-wait slave (ack combinational with stb): each transfer holds stb exactly 1 cycle, one idle cycle between write and read, bus fields stable throughout.
- Run 256 sequences: postcode wraps FF→00; the write carrying 0x0000 occurs at sequence 256.
- POST slave never acks, TIMEOUT=4:
  - stb drops after 4 cycles, err_o=1, postcode_o unchanged, no further cycles;
  - clr_err_i pulse returns to IDLE and the next sequence runs.
- Ack arrives on the exact timeout cycle: transfer succeeds, err_o stays 0.
- enable_i drops during WR_POST with ack delayed 3 cycles: write completes, no read issued, idle until re-enabled.
- Assert wb_rst_n_i low mid-read: all outputs 0 asynchronously; after release, the first write carries 0x0101.
